// File: rtl/ir_pkg.sv
// Shared constants, frame type and state encoding for the IR frame scheduler.
package ir_pkg;

    localparam logic [34:0] KEY_FRAME35 = 35'b10000010000100000000010000001010010;
    localparam logic [31:0] KEY_FRAME32 = 32'b00001000000001000000000000000110;
    localparam int unsigned FRAME_W     = 67;

    typedef logic [FRAME_W-1:0] frame_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_e;

    // Bit width able to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ir_frame_scheduler.sv
// IR frame scheduler: arbitrates key and settings frames, repeats each accepted
// frame with a fixed silence gap, and guards the transmitter with a timeout.
module ir_frame_scheduler
    import ir_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 5000000,
    parameter int unsigned REPEAT         = 2,
    parameter int unsigned TIMEOUT_CYCLES = 31250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_req,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [34:0] cfg_data35,
    input  logic [31:0] cfg_data32,
    output logic        tx_start,
    output logic [34:0] tx_data35,
    output logic [31:0] tx_data32,
    input  logic        tx_done,
    output logic        busy,
    output logic        err_timeout,
    output logic [7:0]  frames_sent
);

    localparam int unsigned CNT_SPAN = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W    = cnt_width(CNT_SPAN);
    localparam int unsigned REP_W    = cnt_width(REPEAT + 1);

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_INIT  = REP_W'(REPEAT);
    localparam frame_t           KEY_FRAME = {KEY_FRAME35, KEY_FRAME32};

    state_e           state_q;
    logic             key_q;
    logic             key_pend_q;
    logic             last_valid_q;
    logic             tx_start_q;
    logic             err_q;
    frame_t           tx_data_q;
    frame_t           last_frame_q;
    logic [REP_W-1:0] rep_cnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       frames_q;

    logic   key_evt;
    logic   pend_eff;
    logic   cfg_xfer;
    logic   cfg_dup;
    frame_t cfg_frame;

    assign key_evt   = key_req & ~key_q;
    // A key edge in this very cycle already counts as pending, so a settings
    // frame offered alongside it waits until the key frame has been sent.
    assign pend_eff  = key_pend_q | key_evt;
    assign cfg_ready = (state_q == ST_IDLE) & ~pend_eff;
    assign cfg_xfer  = cfg_valid & cfg_ready;
    assign cfg_frame = {cfg_data35, cfg_data32};
    assign cfg_dup   = last_valid_q & (cfg_frame == last_frame_q);

    assign tx_start    = tx_start_q;
    assign tx_data35   = tx_data_q[66:32];
    assign tx_data32   = tx_data_q[31:0];
    assign busy        = (state_q != ST_IDLE);
    assign err_timeout = err_q;
    assign frames_sent = frames_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            key_q        <= 1'b0;
            key_pend_q   <= 1'b0;
            last_valid_q <= 1'b0;
            tx_start_q   <= 1'b0;
            err_q        <= 1'b0;
            // NOTE: tx_data and last_frame are plain registers, not memories, so they reset like any other state.
            tx_data_q    <= '0;
            last_frame_q <= '0;
            rep_cnt_q    <= '0;
            cnt_q        <= '0;
            frames_q     <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below sees pre-edge register values.
            key_q      <= key_req;
            key_pend_q <= pend_eff;
            tx_start_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (pend_eff) begin
                        tx_data_q  <= KEY_FRAME;
                        key_pend_q <= 1'b0;
                        rep_cnt_q  <= REP_INIT;
                        tx_start_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end else if (cfg_xfer && !cfg_dup) begin
                        tx_data_q  <= cfg_frame;
                        rep_cnt_q  <= REP_INIT;
                        tx_start_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_DONE;
                end

                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        frames_q     <= frames_q + 8'd1;
                        rep_cnt_q    <= rep_cnt_q - REP_W'(1);
                        last_frame_q <= tx_data_q;
                        last_valid_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= ST_GAP;
                    end else if (cnt_q == TMO_LAST) begin
                        // Abandon the whole frame: no further repeats after a hang.
                        err_q     <= 1'b1;
                        rep_cnt_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        if (rep_cnt_q != '0) begin
                            tx_start_q <= 1'b1;
                            state_q    <= ST_ISSUE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
